// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forwarding selects and scoreboard entries.
// Holds the helper functions used by the match and priority logic.
package hazard_pkg;

    localparam int SB_DEPTH = 3;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        logic     wen;
        reg_idx_t dst;
        logic     is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // $0 is hardwired, so a write to it must never become a forwarding source
    function automatic sb_entry_t sb_make(
        logic     wen,
        reg_idx_t dst,
        logic     is_load
    );
        sb_entry_t e;
        e.valid   = 1'b1;
        e.wen     = wen & (dst != 5'd0);
        e.dst     = dst;
        e.is_load = is_load;
        return e;
    endfunction

    function automatic logic sb_match(
        logic     valid,
        logic     wen,
        reg_idx_t dst,
        reg_idx_t src
    );
        return (src != 5'd0) && valid && wen && (dst == src);
    endfunction

    function automatic fwd_sel_e fwd_pick(
        logic m_ex,
        logic m_mem,
        logic m_wb
    );
        fwd_sel_e sel;
        if (m_ex)
            sel = FWD_EX;
        else if (m_mem)
            sel = FWD_MEM;
        else if (m_wb)
            sel = FWD_WB;
        else
            sel = FWD_REG;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// EX/MEM/WB shadow of in-flight destinations; shifts one stage per edge.
// A frozen pipeline holds every entry; reset drops all of them.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      hold,
    input  sb_entry_t ex_in,
    output sb_entry_t ex_q,
    output sb_entry_t mem_q,
    output sb_entry_t wb_q
);

    sb_entry_t sb_q [SB_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SB_DEPTH; i++)
                sb_q[i] <= SB_EMPTY;
        end else if (!hold) begin
            sb_q[0] <= ex_in;
            for (int i = 1; i < SB_DEPTH; i++)
                sb_q[i] <= sb_q[i-1];
        end
    end

    assign ex_q  = sb_q[0];
    assign mem_q = sb_q[1];
    assign wb_q  = sb_q[2];

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding-select, load-use stall and freeze control for the 5-stage core.
// All control outputs are combinational from the scoreboard and decode inputs.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        de_valid,
    input  logic [4:0]  forward_rs,
    input  logic [4:0]  forward_rt,
    input  logic        de_wen_comb,
    input  logic [4:0]  de_dst,
    input  logic        de_load_comb,
    input  logic        mem_busy,
    output logic        de_stall,
    output logic        ex_bubble,
    output logic        pipe_freeze,
    output logic [1:0]  fwd_sel_rs,
    output logic [1:0]  fwd_sel_rt,
    output logic [15:0] stall_count
);

    sb_entry_t ex_e;
    sb_entry_t mem_e;
    sb_entry_t wb_e;
    sb_entry_t ex_next;

    logic rs_ex, rs_mem, rs_wb;
    logic rt_ex, rt_mem, rt_wb;
    logic load_use;

    // WB and MEM load flags do not matter: only an EX load can stall
    logic unused_load_bits;
    assign unused_load_bits = mem_e.is_load ^ wb_e.is_load;

    assign rs_ex  = sb_match(ex_e.valid,  ex_e.wen,  ex_e.dst,  forward_rs);
    assign rs_mem = sb_match(mem_e.valid, mem_e.wen, mem_e.dst, forward_rs);
    assign rs_wb  = sb_match(wb_e.valid,  wb_e.wen,  wb_e.dst,  forward_rs);
    assign rt_ex  = sb_match(ex_e.valid,  ex_e.wen,  ex_e.dst,  forward_rt);
    assign rt_mem = sb_match(mem_e.valid, mem_e.wen, mem_e.dst, forward_rt);
    assign rt_wb  = sb_match(wb_e.valid,  wb_e.wen,  wb_e.dst,  forward_rt);

    assign fwd_sel_rs = fwd_pick(rs_ex, rs_mem, rs_wb);
    assign fwd_sel_rt = fwd_pick(rt_ex, rt_mem, rt_wb);

    assign load_use    = de_valid & ex_e.is_load & (rs_ex | rt_ex);
    assign pipe_freeze = mem_busy;
    assign de_stall    = load_use | mem_busy;
    assign ex_bubble   = load_use & ~mem_busy;

    always_comb begin
        ex_next = SB_EMPTY;
        if (de_valid && !load_use)
            ex_next = sb_make(de_wen_comb, de_dst, de_load_comb);
    end

    hazard_scoreboard u_sb (
        .clk   (clk),
        .reset (reset),
        .hold  (mem_busy),
        .ex_in (ex_next),
        .ex_q  (ex_e),
        .mem_q (mem_e),
        .wb_q  (wb_e)
    );

    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= 16'd0;
        else if (!mem_busy && load_use && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks of hazard_ctrl forwarding, load-use stall, freeze and reset.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        de_valid;
    logic [4:0]  forward_rs;
    logic [4:0]  forward_rt;
    logic        de_wen_comb;
    logic [4:0]  de_dst;
    logic        de_load_comb;
    logic        mem_busy;
    logic        de_stall;
    logic        ex_bubble;
    logic        pipe_freeze;
    logic [1:0]  fwd_sel_rs;
    logic [1:0]  fwd_sel_rt;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .de_valid     (de_valid),
        .forward_rs   (forward_rs),
        .forward_rt   (forward_rt),
        .de_wen_comb  (de_wen_comb),
        .de_dst       (de_dst),
        .de_load_comb (de_load_comb),
        .mem_busy     (mem_busy),
        .de_stall     (de_stall),
        .ex_bubble    (ex_bubble),
        .pipe_freeze  (pipe_freeze),
        .fwd_sel_rs   (fwd_sel_rs),
        .fwd_sel_rt   (fwd_sel_rt),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic wen,
                         input logic [4:0] dst, input logic ld,
                         input logic busy);
        de_valid     = v;
        forward_rs   = rs;
        forward_rt   = rt;
        de_wen_comb  = wen;
        de_dst       = dst;
        de_load_comb = ld;
        mem_busy     = busy;
        #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;

        // reset state
        check("rst_stall",  de_stall,    0);
        check("rst_bubble", ex_bubble,   0);
        check("rst_freeze", pipe_freeze, 0);
        check("rst_rs",     fwd_sel_rs,  0);
        check("rst_rt",     fwd_sel_rt,  0);
        check("rst_cnt",    stall_count, 0);

        // ADDU $3 ; ADDU $4,$3,$3
        drive(1, 1, 2, 1, 3, 0, 0);
        check("alu_first_rs", fwd_sel_rs, 0);
        tick();
        drive(1, 3, 3, 1, 4, 0, 0);
        check("alu_rs",    fwd_sel_rs, 1);
        check("alu_rt",    fwd_sel_rt, 1);
        check("alu_stall", de_stall,   0);
        tick();
        drain();

        // LW $5 ; ADDU $6,$5,$0
        drive(1, 1, 0, 1, 5, 1, 0);
        tick();
        drive(1, 5, 0, 1, 6, 0, 0);
        check("lu_stall",  de_stall,  1);
        check("lu_bubble", ex_bubble, 1);
        check("lu_rt",     fwd_sel_rt, 0);
        tick();
        check("lu_after_rs",    fwd_sel_rs,  2);
        check("lu_after_stall", de_stall,    0);
        check("lu_after_cnt",   stall_count, 1);
        tick();
        drain();

        // ADDIU $7 ; ORI $7,$7 ; SW rt=$7 ; gap ; reader of $7
        drive(1, 1, 0, 1, 7, 0, 0);
        tick();
        drive(1, 7, 0, 1, 7, 0, 0);
        check("ori_rs", fwd_sel_rs, 1);
        tick();
        drive(1, 2, 7, 0, 0, 0, 0);
        check("sw_rt_young", fwd_sel_rt, 1);
        check("sw_rs",       fwd_sel_rs, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 7, 0, 0, 0, 0, 0);
        check("wb_rs", fwd_sel_rs, 3);
        tick();
        drain();

        // LW $5 ; ADDU $5 (independent) ; reader of $5: no stall on older load
        drive(1, 1, 0, 1, 5, 1, 0);
        tick();
        drive(1, 1, 1, 1, 5, 0, 0);
        check("old_ld_indep_stall", de_stall, 0);
        tick();
        drive(1, 5, 0, 1, 6, 0, 0);
        check("old_ld_rs",    fwd_sel_rs, 1);
        check("old_ld_stall", de_stall,   0);
        tick();
        drain();

        // writes and loads to $0 never forward or stall
        drive(1, 1, 0, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 8, 0, 0);
        check("r0_rs", fwd_sel_rs, 0);
        check("r0_rt", fwd_sel_rt, 0);
        tick();
        drive(1, 1, 0, 1, 0, 1, 0);
        tick();
        drive(1, 0, 0, 1, 9, 0, 0);
        check("r0_ld_stall", de_stall, 0);
        check("r0_ld_rs",    fwd_sel_rs, 0);
        tick();
        drain();

        // LW $5 ; dependent with mem_busy for 3 cycles
        drive(1, 1, 0, 1, 5, 1, 0);
        tick();
        drive(1, 5, 0, 1, 6, 0, 1);
        check("busy_freeze", pipe_freeze, 1);
        check("busy_stall",  de_stall,    1);
        check("busy_bubble", ex_bubble,   0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("busy_held_rs",  fwd_sel_rs,  (i < 2) ? 1 : 1);
            check("busy_held_cnt", stall_count, 1);
        end
        mem_busy = 1'b0;
        #1;
        check("busy_rel_bubble", ex_bubble,   1);
        check("busy_rel_freeze", pipe_freeze, 0);
        tick();
        check("busy_after_rs",    fwd_sel_rs,  2);
        check("busy_after_stall", de_stall,    0);
        check("busy_after_cnt",   stall_count, 2);
        tick();
        drain();

        // three in-flight writers, then reset with mem_busy high
        drive(1, 0, 0, 1, 8, 0, 0);
        tick();
        drive(1, 0, 0, 1, 9, 0, 0);
        tick();
        drive(1, 0, 0, 1, 10, 0, 0);
        tick();
        drive(1, 8, 9, 0, 0, 0, 0);
        check("pre_rst_rs", fwd_sel_rs, 3);
        check("pre_rst_rt", fwd_sel_rt, 2);
        reset    = 1'b1;
        mem_busy = 1'b1;
        tick();
        reset    = 1'b0;
        mem_busy = 1'b0;
        #1;
        check("post_rst_rs",     fwd_sel_rs,  0);
        check("post_rst_rt",     fwd_sel_rt,  0);
        check("post_rst_cnt",    stall_count, 0);
        check("post_rst_stall",  de_stall,    0);
        check("post_rst_bubble", ex_bubble,   0);
        mem_busy = 1'b1;
        #1;
        check("post_rst_freeze", pipe_freeze, 1);
        mem_busy = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
